alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Multi-cycle, parametrised successor to the team's combinational 4-bit ALU.
- Adds valid/ready handshakes on both sides, registered outputs and a persistent flag register (Z/C/N/V).
- Adds carry-chained ops (ADC/SBC), barrel shifts by operand amount, and an iterative multiplier.
- Sits between the CPU decode/issue stage and writeback; one operation is in flight at a time.

Parameters:
- WIDTH, 8, operand/result width; legal range 4..32.
- SH_W, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- op  in  4  opcode.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; for shifts, b[SH_W-1:0] is the shift amount.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- flag_z  out  1  zero flag (registered).
- flag_c  out  1  carry/borrow flag (registered).
- flag_n  out  1  negative flag = result MSB.
- flag_v  out  1  signed overflow flag.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous): state=IDLE, result=0, all flags=0, out_valid=0, busy=0, in_ready=1. Reset mid-operation aborts the op with no output.
- FSM states: IDLE, EXEC_MC, DONE.
  - in_ready = (state==IDLE).
  - Accept on in_valid && in_ready; a, b and op are latched.
- Single-cycle ops: IDLE -> DONE. out_valid rises on the cycle after accept (latency 1).
- MUL: IDLE -> EXEC_MC for WIDTH cycles -> DONE. out_valid is asserted WIDTH+1 cycles after accept.
- DONE: out_valid=1; result and flags are held stable until out_ready. Then -> IDLE with out_valid=0. No same-cycle re-accept in DONE.
- Flag register updates only when the result is produced (entry to DONE). flag_n = result[WIDTH-1] for every op.
- Opcodes and flags:
  - 0 ADD: C = carry-out; V = signed overflow.
  - 1 SUB: a-b; C = borrow (a<b unsigned); V = signed overflow.
  - 2 AND, 3 OR, 4 XOR, 5 NOT(~a): C=0, V=0.
  - 6 SHL by b[SH_W-1:0]: C = last bit shifted out; amount 0 -> C=0. V=0.
  - 7 SHR logical: same C rule as SHL. V=0.
  - 8 ASR arithmetic (sign-fill): same C rule as SHL. V=0.
  - 9 ADC: a+b+flag_c (stored flag); C and V as ADD.
  - A SBC: a-b-flag_c; C and V as SUB.
  - B MUL: result = low WIDTH bits of the unsigned product; C = 1 if the high half is nonzero; V=0.
  - C DIV: only when the optional feature is compiled in, otherwise illegal.
  - D-F illegal: single-cycle; result=0, Z=1, C=0, V=0.
- Z = (result==0) for every op.
- All arithmetic is carried out in WIDTH+1 bits; no X propagates from unused operand bits.

Optional Feature:
- Macro: ALU_MC_DIV_EN.
- Defined: op C = unsigned restoring divide, quotient to result, iterative over WIDTH cycles (same latency as MUL). b==0 -> result all ones, C=1, V=0.
- Undefined: op C behaves as an illegal opcode; no divider logic is synthesised.

Decomposition:
- Shared package alu_mc_pkg holds:
  - 4-bit opcode constants (OP_ADD..OP_DIV).
  - FSM state encodings.
  - Flag bit indices (FLAG_Z/C/N/V).
- Sub-module alu_mc_iter: shift-add multiplier with start/done handshake, WIDTH-cycle iteration. It hosts the restoring divider under ALU_MC_DIV_EN.
- Top level keeps the FSM, the single-cycle datapath and the flag register.

Test Plan (WIDTH=8):
- ADD a=0xFF b=0x01 -> result 0x00, Z=1 C=1 N=0 V=0, out_valid exactly 1 cycle after accept. Then ADC a=0x10 b=0x20 -> 0x31, C=0.
- SUB a=0x80 b=0x01 -> 0x7F, V=1 N=0 C=0. SUB a=0x01 b=0x02 -> 0xFF, C=1 N=1.
- ASR a=0x90 b=2 -> 0xE4, C=0. SHL a=0x81 b=1 -> 0x02, C=1. SHR with shift amount 0 -> result=a, C=0.
- MUL a=0x10 b=0x20 -> 0x00, Z=1 C=1; MUL 0x0C*0x0A -> 0x78 C=0. out_valid 9 cycles after accept; in_ready=0 and busy=1 throughout.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> result and flags stable, in_ready=0. Back-to-back requests are accepted only after the handshake.
- Reset asserted in cycle 4 of a MUL -> next cycle state=IDLE, out_valid=0, flags=0, in_ready=1. Illegal op 0xE -> 0x00, Z=1. With ALU_MC_DIV_EN: DIV 0x64/0x07 -> 0x0E; DIV by 0 -> 0xFF, C=1.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states, flag bit positions.
package alu_mc_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_ASR = 4'h8;
  localparam logic [3:0] OP_ADC = 4'h9;
  localparam logic [3:0] OP_SBC = 4'hA;
  localparam logic [3:0] OP_MUL = 4'hB;
  localparam logic [3:0] OP_DIV = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC_MC = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative engine for the multi-cycle ALU: shift-add unsigned multiplier, and a
// restoring unsigned divider when ALU_MC_DIV_EN is defined.
// The first iteration runs on the start cycle itself, so o_done is seen WIDTH-1
// cycles after i_start and the top can register the result one cycle later.
// {o_hi, o_lo} is the 2*WIDTH product; for divide o_lo is the quotient.
module alu_mc_iter
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
`ifdef ALU_MC_DIV_EN
  input  logic             i_div,
`endif
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             r_run;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd;

  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_opnd;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_nxt_hi;
  logic [WIDTH-1:0] w_nxt_lo;

  // On start the step operates on the fresh operands instead of the registers
  assign w_hi   = i_start ? '0  : r_hi;
  assign w_lo   = i_start ? i_a : r_lo;
  assign w_opnd = i_start ? i_b : r_opnd;

`ifdef ALU_MC_DIV_EN
  logic           r_div;
  logic           w_div;
  logic [WIDTH:0] w_trial;
  assign w_div = i_start ? i_div : r_div;
`endif

  // One iteration: add-and-shift-right for multiply, trial-subtract for divide
  always_comb begin
    w_sum    = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_opnd} : '0);
    w_nxt_hi = w_sum[WIDTH:1];
    w_nxt_lo = {w_sum[0], w_lo[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
    w_trial = {w_hi, w_lo[WIDTH-1]} - {1'b0, w_opnd};
    if (w_div) begin
      if (!w_trial[WIDTH]) begin
        w_nxt_hi = w_trial[WIDTH-1:0];
        w_nxt_lo = {w_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_nxt_hi = {w_hi[WIDTH-2:0], w_lo[WIDTH-1]};
        w_nxt_lo = {w_lo[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  // Iteration down-counter and working registers; done at terminal count zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run  <= 1'b0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_opnd <= '0;
`ifdef ALU_MC_DIV_EN
      r_div  <= 1'b0;
`endif
    end else if (i_start) begin
      r_run  <= 1'b1;
      r_cnt  <= CNT_W'(WIDTH - 1);
      r_hi   <= w_nxt_hi;
      r_lo   <= w_nxt_lo;
      r_opnd <= i_b;
`ifdef ALU_MC_DIV_EN
      r_div  <= i_div;
`endif
    end else if (r_run) begin
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
        r_hi  <= w_nxt_hi;
        r_lo  <= w_nxt_lo;
      end else begin
        r_run <= 1'b0;
      end
    end
  end

  assign o_done = r_run && (r_cnt == '0);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides, registered result and a
// persistent Z/C/N/V flag register. Optional divide under ALU_MC_DIV_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | ready for a request; single-cycle ops resolve on accept
// ST_EXEC_MC | multiply/divide iterating in alu_mc_iter
// ST_DONE    | result and flags presented, held until out_ready
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v,
  output logic             busy
);

  localparam int SH_W = $clog2(WIDTH);

  state_t           r_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic             r_out_valid;

  logic             w_is_iter;
  logic             w_it_start;
  logic             w_it_done;
  logic [WIDTH-1:0] w_it_hi;
  logic [WIDTH-1:0] w_it_lo;
  logic             w_cin;
  logic [SH_W-1:0]  w_sh;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;
  logic [WIDTH:0]   w_asr;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic [3:0]       w_flags;

`ifdef ALU_MC_DIV_EN
  logic r_b_zero;
  assign w_is_iter = (op == OP_MUL) || (op == OP_DIV);
`else
  assign w_is_iter = (op == OP_MUL);
`endif

  assign w_it_start = (r_state == ST_IDLE) && in_valid && w_is_iter;

  alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_it_start),
`ifdef ALU_MC_DIV_EN
    .i_div   (op == OP_DIV),
`endif
    .i_a     (a),
    .i_b     (b),
    .o_done  (w_it_done),
    .o_hi    (w_it_hi),
    .o_lo    (w_it_lo)
  );

  // Carry-chained ops pull in the stored C flag; the extra MSB is carry/borrow
  assign w_cin = ((op == OP_ADC) || (op == OP_SBC)) && r_flags[FLAG_C];
  assign w_sh  = b[SH_W-1:0];
  assign w_add = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, w_cin};
  assign w_sub = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, w_cin};
  // Guard bit on the far side of each shift catches the last bit shifted out
  assign w_shl = {1'b0, a} << w_sh;
  assign w_shr = {a, 1'b0} >> w_sh;
  assign w_asr = $signed({a, 1'b0}) >>> w_sh;

  // Next result and C/V: iterative result in EXEC_MC, otherwise from the live request
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    if (r_state == ST_EXEC_MC) begin
      case (r_op)
        OP_MUL: begin
          w_res = w_it_lo;
          w_c   = |w_it_hi;
        end
`ifdef ALU_MC_DIV_EN
        OP_DIV: begin
          w_res = w_it_lo;
          w_c   = r_b_zero;
        end
`endif
        default: ;
      endcase
    end else begin
      case (op)
        OP_ADD, OP_ADC: begin
          w_res = w_add[WIDTH-1:0];
          w_c   = w_add[WIDTH];
          w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
        end
        OP_SUB, OP_SBC: begin
          w_res = w_sub[WIDTH-1:0];
          w_c   = w_sub[WIDTH];
          w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
        end
        OP_AND: w_res = a & b;
        OP_OR:  w_res = a | b;
        OP_XOR: w_res = a ^ b;
        OP_NOT: w_res = ~a;
        OP_SHL: begin
          w_res = w_shl[WIDTH-1:0];
          w_c   = w_shl[WIDTH];
        end
        OP_SHR: begin
          w_res = w_shr[WIDTH:1];
          w_c   = w_shr[0];
        end
        OP_ASR: begin
          w_res = w_asr[WIDTH:1];
          w_c   = w_asr[0];
        end
        default: ;
      endcase
    end
    w_flags         = '0;
    w_flags[FLAG_Z] = (w_res == '0);
    w_flags[FLAG_C] = w_c;
    w_flags[FLAG_N] = w_res[WIDTH-1];
    w_flags[FLAG_V] = w_v;
  end

  // Control FSM; result and flags are captured only on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_ADD;
      r_result    <= '0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
`ifdef ALU_MC_DIV_EN
      r_b_zero    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op <= op;
`ifdef ALU_MC_DIV_EN
            r_b_zero <= (b == '0);
`endif
            if (w_is_iter) begin
              r_state <= ST_EXEC_MC;
            end else begin
              r_state     <= ST_DONE;
              r_result    <= w_res;
              r_flags     <= w_flags;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_EXEC_MC: begin
          if (w_it_done) begin
            r_state     <= ST_DONE;
            r_result    <= w_res;
            r_flags     <= w_flags;
            r_out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flag_z    = r_flags[FLAG_Z];
  assign flag_c    = r_flags[FLAG_C];
  assign flag_n    = r_flags[FLAG_N];
  assign flag_v    = r_flags[FLAG_V];

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (WIDTH=8). Expected flags are packed {V,N,C,Z}.
module tb_alu_mc;
  import alu_mc_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       flag_z, flag_c, flag_n, flag_v;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] res;
    logic [3:0] flg;
  } exp_t;

  exp_t exp_q[$];

  alu_mc #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_n    (flag_n),
    .flag_v    (flag_v),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got result 0x%0h with empty scoreboard, expected none", result);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_result"}, {24'd0, result}, {24'd0, e.res});
          check({e.name, "_flags"}, {28'd0, flag_v, flag_n, flag_c, flag_z}, {28'd0, e.flg});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Issue one request, push its expectation, and measure cycles to out_valid
  task automatic issue(input string nm, input logic [3:0] o, input logic [7:0] x,
                       input logic [7:0] y, input logic [7:0] er, input logic [3:0] ef,
                       input int lat);
    int   cyc;
    exp_t e;
    @(negedge clk);
    check({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    e.name = nm;
    e.res  = er;
    e.flg  = ef;
    exp_q.push_back(e);
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 50) begin
      check({nm, "_busy_exec"}, {31'd0, busy}, 32'd1);
      check({nm, "_in_ready_exec"}, {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      cyc++;
    end
    check({nm, "_latency"}, cyc, lat);
    check({nm, "_busy_done"}, {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    op = 4'h0;
    a = 8'h00;
    b = 8'h00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", {24'd0, result}, 32'd0);
    check("reset_flags", {28'd0, flag_v, flag_n, flag_c, flag_z}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue("add_ff_01",  OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b0011, 1);
    issue("adc_cin1",   OP_ADC, 8'h10, 8'h20, 8'h31, 4'b0000, 1);
    issue("add_ovf",    OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b1100, 1);
    issue("sub_ovf",    OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b1000, 1);
    issue("and",        OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1);
    issue("or",         OP_OR,  8'h0F, 8'hF0, 8'hFF, 4'b0100, 1);
    issue("xor_zero",   OP_XOR, 8'hAA, 8'hAA, 8'h00, 4'b0001, 1);
    issue("not",        OP_NOT, 8'h0F, 8'hFF, 8'hF0, 4'b0100, 1);
    issue("asr_90_2",   OP_ASR, 8'h90, 8'h02, 8'hE4, 4'b0100, 1);
    issue("shl_81_1",   OP_SHL, 8'h81, 8'h01, 8'h02, 4'b0010, 1);
    issue("sbc_cin1",   OP_SBC, 8'h10, 8'h05, 8'h0A, 4'b0000, 1);
    issue("shr_amt0",   OP_SHR, 8'hA5, 8'h08, 8'hA5, 4'b0100, 1);
    issue("shr_a5_3",   OP_SHR, 8'hA5, 8'h03, 8'h14, 4'b0010, 1);
    issue("mul_10_20",  OP_MUL, 8'h10, 8'h20, 8'h00, 4'b0011, 9);
    issue("mul_0c_0a",  OP_MUL, 8'h0C, 8'h0A, 8'h78, 4'b0000, 9);
    issue("illegal_e",  4'hE,   8'h55, 8'hAA, 8'h00, 4'b0001, 1);
    issue("illegal_f",  4'hF,   8'hFF, 8'hFF, 8'h00, 4'b0001, 1);
`ifdef ALU_MC_DIV_EN
    issue("div_64_07",  OP_DIV, 8'h64, 8'h07, 8'h0E, 4'b0000, 9);
    issue("div_by0",    OP_DIV, 8'h64, 8'h00, 8'hFF, 4'b0110, 9);
`else
    issue("op_c_illeg", OP_DIV, 8'h64, 8'h07, 8'h00, 4'b0001, 1);
`endif

    // Backpressure: SUB held in DONE, ADD pending must wait for the handshake
    begin
      exp_t e;
      @(negedge clk);
      out_ready = 1'b0;
      e.name = "sub_bp";
      e.res  = 8'hFF;
      e.flg  = 4'b0110;
      exp_q.push_back(e);
      in_valid = 1'b1;
      op = OP_SUB;
      a = 8'h01;
      b = 8'h02;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("bp_hold_result", {24'd0, result}, 32'h0000_00FF);
        check("bp_hold_flags", {28'd0, flag_v, flag_n, flag_c, flag_z}, 32'h6);
        check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_hold_out_valid", {31'd0, out_valid}, 32'd1);
        if (i == 0) begin
          e.name = "add_after_bp";
          e.res  = 8'h07;
          e.flg  = 4'b0000;
          exp_q.push_back(e);
          in_valid = 1'b1;
          op = OP_ADD;
          a = 8'h03;
          b = 8'h04;
        end
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_released_out_valid", {31'd0, out_valid}, 32'd0);
      check("bp_released_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_next_out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
    end

    issue("add_ff_02",  OP_ADD, 8'hFF, 8'h02, 8'h01, 4'b0010, 1);

    // Reset in cycle 4 of a multiply aborts it with no output
    @(negedge clk);
    in_valid = 1'b1;
    op = OP_MUL;
    a = 8'h03;
    b = 8'h05;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_result", {24'd0, result}, 32'd0);
    check("rst_mid_flags", {28'd0, flag_v, flag_n, flag_c, flag_z}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("rst_mid_no_late_output", {31'd0, out_valid}, 32'd0);

    issue("adc_after_rst", OP_ADC, 8'h01, 8'h01, 8'h02, 4'b0000, 1);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
